ma_stage_ls: RTL and testbench

//  Parametrised memory-access stage for the MIPS pipeline: owns data memory, executes
//  LB/LBU/LH/LHU/LW/SB/SH/SW with byte lanes and configurable memory wait states, and

---
 rtl/ma_stage_ls.sv | 188 ++++++++++++++++++
 tb/tb_ma_stage_ls.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage_ls.sv
// Memory-access stage: data memory with byte lanes, optional wait states, and
// write-back selection (load data, store data, link address or ALU result).
module ma_stage_ls #(
    parameter int DMEM_WORDS  = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    input  logic [31:0] nextPC,
    output logic        out_valid,
    output logic [31:0] Wdata,
    output logic        misalign_exc,
    output logic [31:0] fault_addr
);
    localparam int AW = $clog2(DMEM_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [5:0] OP_RFORM = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;
    logic [AW+1:0] addr_q;
    logic [31:0] sdata_q, wdata_q, fault_q;
    logic        is_load_q, is_store_q, exc_q;

    logic [5:0]  in_op;
    logic        in_ld, in_st, in_mis, in_link, accept;
    logic        unused_ins;

    assign in_op   = Ins[31:26];
    assign in_ld   = (in_op == OP_LB) || (in_op == OP_LH) || (in_op == OP_LW) ||
                     (in_op == OP_LBU) || (in_op == OP_LHU);
    assign in_st   = (in_op == OP_SB) || (in_op == OP_SH) || (in_op == OP_SW);
    assign in_mis  = (((in_op == OP_LH) || (in_op == OP_LHU) || (in_op == OP_SH)) && Result[0]) ||
                     (((in_op == OP_LW) || (in_op == OP_SW)) && (Result[1:0] != 2'b00));
    assign in_link = (in_op == OP_JAL) || ((in_op == OP_RFORM) && (Ins[5:0] == FN_JALR));
    assign unused_ins = ^Ins[25:6];

    assign in_ready  = RST && (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if ((in_ld || in_st) && !in_mis) begin
                        if (WAIT_CYCLES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_INIT;
                        end else begin
                            state_d = S_ACCESS;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane geometry: op_q[1:0] is 00 byte, 01 half, 11 word for every load/store opcode.
    logic [1:0]  byte_pos;
    logic        half_pos;
    logic [3:0]  be;
    logic [31:0] st_word, rd_word, load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [AW-1:0] idx;
    logic        mem_we;

    assign idx    = addr_q[2 +: AW];
    assign mem_we = (state_q == S_ACCESS) && is_store_q;

    always_comb begin
        byte_pos = (BIG_ENDIAN != 0) ? (2'd3 - addr_q[1:0]) : addr_q[1:0];
        half_pos = (BIG_ENDIAN != 0) ? ~addr_q[1] : addr_q[1];
        ld_byte  = rd_word[{byte_pos, 3'b000} +: 8];
        ld_half  = rd_word[{half_pos, 4'b0000} +: 16];
        be       = 4'b1111;
        st_word  = sdata_q;
        load_val = rd_word;
        case (op_q[1:0])
            2'b00: begin
                be       = 4'b0001 << byte_pos;
                st_word  = {4{sdata_q[7:0]}};
                load_val = op_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                be       = half_pos ? 4'b1100 : 4'b0011;
                st_word  = {2{sdata_q[15:0]}};
                load_val = op_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

    // One byte-wide RAM per physical byte lane, each with its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_q [DMEM_WORDS];
        logic [7:0] rd_b_q;
        always_ff @(posedge CLK) begin
            if (mem_we && be[gi]) begin
                mem_q[idx] <= st_word[gi*8 +: 8];
            end
            rd_b_q <= mem_q[idx];
        end
        assign rd_word[gi*8 +: 8] = rd_b_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q       <= 4'd0;
            addr_q     <= '0;
            sdata_q    <= 32'd0;
            wdata_q    <= 32'd0;
            fault_q    <= 32'd0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            exc_q      <= 1'b0;
        end else if (accept) begin
            op_q       <= Ins[29:26];
            addr_q     <= Result[AW+1:0];
            sdata_q    <= Rdata2;
            is_load_q  <= in_ld && !in_mis;
            is_store_q <= in_st && !in_mis;
            exc_q      <= in_mis;
            fault_q    <= in_mis ? Result : 32'd0;
            if (in_mis || in_ld) begin
                wdata_q <= 32'd0;
            end else if (in_st) begin
                wdata_q <= Rdata2;
            end else if (in_link) begin
                wdata_q <= nextPC;
            end else begin
                wdata_q <= Result;
            end
        end else if ((state_q == S_DONE) && is_load_q) begin
            wdata_q <= load_val;
        end
    end

    // Load data is only available from the RAM output register during DONE.
    assign Wdata        = ((state_q == S_DONE) && is_load_q) ? load_val : wdata_q;
    assign misalign_exc = exc_q;
    assign fault_addr   = fault_q;

endmodule

// File: tb/tb_ma_stage_ls.sv
// Directed bench for ma_stage_ls: dut_a (WAIT 1, big-endian), dut_b (WAIT 3, little-endian).
module tb_ma_stage_ls;
    localparam logic [5:0] OP_JAL = 6'h03, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                           OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29,
                           OP_SW = 6'h2B, OP_ADDI = 6'h08;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid, in_ready, out_valid, mexc;
    logic [31:0] ins [2];
    logic [31:0] res [2];
    logic [31:0] rd2 [2];
    logic [31:0] npc [2];
    logic [31:0] wdata [2];
    logic [31:0] faddr [2];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ma_stage_ls #(.DMEM_WORDS(1024), .WAIT_CYCLES(1), .BIG_ENDIAN(1)) dut_a (
        .CLK(clk), .RST(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .Ins(ins[0]), .Result(res[0]), .Rdata2(rd2[0]), .nextPC(npc[0]),
        .out_valid(out_valid[0]), .Wdata(wdata[0]), .misalign_exc(mexc[0]),
        .fault_addr(faddr[0]));

    ma_stage_ls #(.DMEM_WORDS(256), .WAIT_CYCLES(3), .BIG_ENDIAN(0)) dut_b (
        .CLK(clk), .RST(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .Ins(ins[1]), .Result(res[1]), .Rdata2(rd2[1]), .nextPC(npc[1]),
        .out_valid(out_valid[1]), .Wdata(wdata[1]), .misalign_exc(mexc[1]),
        .fault_addr(faddr[1]));

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'd0};
    endfunction

    // Issue one instruction and report the result seen with out_valid and its latency.
    task automatic run_op(input int s, input logic [31:0] i, input logic [31:0] r,
                          input logic [31:0] d, input logic [31:0] p,
                          output logic [31:0] wd, output logic ex,
                          output logic [31:0] fa, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready[s] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ins[s] = i; res[s] = r; rd2[s] = d; npc[s] = p;
        in_valid[s] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
        lat = 1;
        while (!out_valid[s] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        wd = wdata[s]; ex = mexc[s]; fa = faddr[s];
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_valid !== 2'b00 || wdata[0] !== 32'd0 || mexc[0] !== 1'b0 || faddr[0] !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: out_valid=%b Wdata=%h exc=%b fault=%h required 00/0/0/0",
                     out_valid, wdata[0], mexc[0], faddr[0]);
        end
        n_vec++;
        if (in_ready !== 2'b00) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b required 00", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 2'b11) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b required 11", in_ready);
        end
    endtask

    task automatic test_store_load_be();
        logic [31:0] wd, fa; logic ex; int lat;
        run_op(0, mk(OP_SW), 32'h40, 32'h11223344, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h11223344 || ex !== 1'b0 || lat !== 3) begin
            n_err++;
            $display("FAIL sw_40: Wdata=%h exc=%b lat=%0d required 11223344/0/3", wd, ex, lat);
        end
        run_op(0, mk(OP_LB), 32'h41, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h00000022 || lat !== 3) begin
            n_err++;
            $display("FAIL lb_41: Wdata=%h lat=%0d required 00000022/3", wd, lat);
        end
        run_op(0, mk(OP_LH), 32'h40, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h00001122) begin
            n_err++;
            $display("FAIL lh_40: Wdata=%h required 00001122", wd);
        end
    endtask

    task automatic test_byte_half_store();
        logic [31:0] wd, fa; logic ex; int lat;
        run_op(0, mk(OP_SB), 32'h42, 32'hABCDEFFF, 32'h0, wd, ex, fa, lat);
        run_op(0, mk(OP_LW), 32'h40, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h1122FF44) begin
            n_err++;
            $display("FAIL sb_42_word: Wdata=%h required 1122ff44", wd);
        end
        run_op(0, mk(OP_LB), 32'h42, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'hFFFFFFFF) begin
            n_err++;
            $display("FAIL lb_42: Wdata=%h required ffffffff", wd);
        end
        run_op(0, mk(OP_LBU), 32'h42, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h000000FF) begin
            n_err++;
            $display("FAIL lbu_42: Wdata=%h required 000000ff", wd);
        end
        run_op(0, mk(OP_SH), 32'h40, 32'h12348001, 32'h0, wd, ex, fa, lat);
        run_op(0, mk(OP_LW), 32'h40, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h8001FF44) begin
            n_err++;
            $display("FAIL sh_40_word: Wdata=%h required 8001ff44", wd);
        end
        run_op(0, mk(OP_LH), 32'h40, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'hFFFF8001) begin
            n_err++;
            $display("FAIL lh_40_sign: Wdata=%h required ffff8001", wd);
        end
        run_op(0, mk(OP_LHU), 32'h42, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h0000FF44) begin
            n_err++;
            $display("FAIL lhu_42: Wdata=%h required 0000ff44", wd);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] wd, fa; logic ex; int lat;
        run_op(0, mk(OP_LH), 32'h43, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (ex !== 1'b1 || fa !== 32'h43 || wd !== 32'd0 || lat !== 1) begin
            n_err++;
            $display("FAIL lh_43_mis: exc=%b fault=%h Wdata=%h lat=%0d required 1/43/0/1", ex, fa, wd, lat);
        end
        run_op(0, mk(OP_SW), 32'h44, 32'h55667788, 32'h0, wd, ex, fa, lat);
        run_op(0, mk(OP_SW), 32'h46, 32'hDEADBEEF, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (ex !== 1'b1 || fa !== 32'h46 || wd !== 32'd0 || lat !== 1) begin
            n_err++;
            $display("FAIL sw_46_mis: exc=%b fault=%h Wdata=%h lat=%0d required 1/46/0/1", ex, fa, wd, lat);
        end
        run_op(0, mk(OP_LW), 32'h44, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h55667788 || ex !== 1'b0) begin
            n_err++;
            $display("FAIL sw_46_nowrite: Wdata=%h exc=%b required 55667788/0", wd, ex);
        end
    endtask

    task automatic test_nonmem();
        logic [31:0] wd, fa; logic ex; int lat;
        run_op(0, mk(OP_JAL), 32'h77, 32'h0, 32'h00001000, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h00001000 || lat !== 1) begin
            n_err++;
            $display("FAIL jal: Wdata=%h lat=%0d required 00001000/1", wd, lat);
        end
        run_op(0, 32'h00000020, 32'h0000ABCD, 32'h0, 32'h00002000, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h0000ABCD || lat !== 1) begin
            n_err++;
            $display("FAIL rform_add: Wdata=%h lat=%0d required 0000abcd/1", wd, lat);
        end
        run_op(0, mk(OP_ADDI), 32'h00000123, 32'h0, 32'h00003000, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h00000123 || ex !== 1'b0) begin
            n_err++;
            $display("FAIL addi: Wdata=%h exc=%b required 00000123/0", wd, ex);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd, fa, wdv; logic ex; int lat, low, ovk, guard;
        run_op(1, mk(OP_SW), 32'h20, 32'h11223344, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h11223344 || lat !== 5) begin
            n_err++;
            $display("FAIL b_sw_20: Wdata=%h lat=%0d required 11223344/5", wd, lat);
        end
        run_op(1, mk(OP_LB), 32'h21, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h00000033 || lat !== 5) begin
            n_err++;
            $display("FAIL b_lb_21_le: Wdata=%h lat=%0d required 00000033/5", wd, lat);
        end
        @(negedge clk);
        guard = 0;
        while (!in_ready[1] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ins[1] = mk(OP_LW); res[1] = 32'h20; in_valid[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            low = 0; ovk = 0; wdv = 32'd0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (out_valid[1]) begin
                    ovk = k;
                    wdv = wdata[1];
                end
                if (in_ready[1]) break;
                low++;
            end
            n_vec++;
            if (low !== 5 || ovk !== 5 || wdv !== 32'h11223344) begin
                n_err++;
                $display("FAIL b2b_lw_%0d: ready_low=%0d out_valid_at=%0d Wdata=%h required 5/5/11223344",
                         t, low, ovk, wdv);
            end
        end
        in_valid[1] = 1'b0;
        run_op(1, 32'h03E00009, 32'h5, 32'h0, 32'h00002468, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'h00002468 || lat !== 1) begin
            n_err++;
            $display("FAIL b_jalr: Wdata=%h lat=%0d required 00002468/1", wd, lat);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wd, fa; logic ex; int lat;
        run_op(0, mk(OP_SW), 32'h00001008, 32'hCAFEF00D, 32'h0, wd, ex, fa, lat);
        run_op(0, mk(OP_LW), 32'h00000008, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'hCAFEF00D || lat !== 3) begin
            n_err++;
            $display("FAIL wrap_lw_8: Wdata=%h lat=%0d required cafef00d/3", wd, lat);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] wd, fa; logic ex; int lat, bad, guard;
        run_op(0, mk(OP_SW), 32'h80, 32'hAAAA5555, 32'h0, wd, ex, fa, lat);
        @(negedge clk);
        guard = 0;
        while (!in_ready[0] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ins[0] = mk(OP_SW); res[0] = 32'h80; rd2[0] = 32'h12345678; in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_mid_wait: %0d cycles with out_valid/in_ready high, required 0", bad);
        end
        rst_n = 1'b1;
        run_op(0, mk(OP_LW), 32'h80, 32'h0, 32'h0, wd, ex, fa, lat);
        n_vec++;
        if (wd !== 32'hAAAA5555) begin
            n_err++;
            $display("FAIL reset_no_write: Wdata=%h required aaaa5555", wd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ins[i] = 32'd0; res[i] = 32'd0; rd2[i] = 32'd0; npc[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_store_load_be();
        test_byte_half_store();
        test_misaligned();
        test_nonmem();
        test_back_to_back();
        test_wrap();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
